// File: rtl/flash_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the byte-wide Flash controller.
// The arbiter connects through the slave modport; the requester/controller side uses master.
interface flash_arbiter_if;
    logic       a_req;
    logic       a_rw;
    logic [7:0] a_addr;
    logic [7:0] a_wdata;
    logic       a_ack;
    logic [7:0] a_rdata;

    logic       b_req;
    logic       b_rw;
    logic [7:0] b_addr;
    logic [7:0] b_wdata;
    logic       b_ack;
    logic [7:0] b_rdata;

    logic [7:0] fb_addr;
    logic [7:0] fb_data;
    logic       fb_direction_rw;
    logic       fb_start;
    logic       fb_done;
    logic [7:0] fb_rdata;

    logic       busy;
    logic       timeout_err;

    modport slave (
        input  a_req, a_rw, a_addr, a_wdata,
        input  b_req, b_rw, b_addr, b_wdata,
        input  fb_done, fb_rdata,
        output a_ack, a_rdata, b_ack, b_rdata,
        output fb_addr, fb_data, fb_direction_rw, fb_start,
        output busy, timeout_err
    );

    modport master (
        output a_req, a_rw, a_addr, a_wdata,
        output b_req, b_rw, b_addr, b_wdata,
        output fb_done, fb_rdata,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  fb_addr, fb_data, fb_direction_rw, fb_start,
        input  busy, timeout_err
    );
endinterface

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing one Flash controller command port between requesters A and B,
// with start sequencing, completion timeout and an enforced idle gap after each operation.
module flash_arbiter #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic           CLK_50MHZ,
    input  logic           RST,
    flash_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 1 = B was granted most recently
    logic        fb_done_q;
    logic [15:0] tmo_cnt_q, tmo_cnt_d, tmo_inc;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [7:0]  a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [7:0]  fb_addr_q, fb_addr_d, fb_data_q, fb_data_d;
    logic        fb_rw_q, fb_rw_d, fb_start_q, fb_start_d;
    logic        busy_q, busy_d, timeout_q, timeout_d;
    logic        done_rise, pick_b;

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            fb_done_q    <= 1'b0;
            tmo_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            fb_rw_q      <= 1'b0;
            fb_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            fb_done_q    <= bus.fb_done;
            tmo_cnt_q    <= tmo_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fb_rw_q      <= fb_rw_d;
            fb_start_q   <= fb_start_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    // The counter reads 0 during the start cycle, so the timeout pulse lands TIMEOUT_CYCLES-1 after it.
    always_comb begin
        done_rise    = bus.fb_done & ~fb_done_q;
        tmo_inc      = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
        pick_b       = bus.b_req & (~bus.a_req | ~last_grant_q);

        state_d      = state_q;
        last_grant_d = last_grant_q;
        tmo_cnt_d    = tmo_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        fb_rw_d      = fb_rw_q;
        fb_start_d   = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    last_grant_d = pick_b;
                    fb_addr_d    = pick_b ? bus.b_addr  : bus.a_addr;
                    fb_data_d    = pick_b ? bus.b_wdata : bus.a_wdata;
                    fb_rw_d      = pick_b ? bus.b_rw    : bus.a_rw;
                    fb_start_d   = 1'b1;
                    tmo_cnt_d    = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                tmo_cnt_d = tmo_inc;
                state_d   = WAIT;
            end
            WAIT: begin
                tmo_cnt_d = tmo_inc;
                if (done_rise) begin
                    if (fb_rw_q) begin
                        if (last_grant_q) b_rdata_d = bus.fb_rdata;
                        else              a_rdata_d = bus.fb_rdata;
                    end
                    a_ack_d   = ~last_grant_q;
                    b_ack_d   = last_grant_q;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else if (tmo_inc >= TMO_LAST) begin
                    a_ack_d   = ~last_grant_q;
                    b_ack_d   = last_grant_q;
                    timeout_d = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                // The gap only starts counting once the controller has dropped done.
                if (bus.fb_done) begin
                    gap_cnt_d = '0;
                end else if (gap_cnt_q >= GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.a_ack           = a_ack_q;
    assign bus.b_ack           = b_ack_q;
    assign bus.a_rdata         = a_rdata_q;
    assign bus.b_rdata         = b_rdata_q;
    assign bus.fb_addr         = fb_addr_q;
    assign bus.fb_data         = fb_data_q;
    assign bus.fb_direction_rw = fb_rw_q;
    assign bus.fb_start        = fb_start_q;
    assign bus.busy            = busy_q;
    assign bus.timeout_err     = timeout_q;
endmodule

// File: doc/flash_arbiter.md
Name: flash_arbiter

Overview:
- Shares the single byte-wide Flash controller command interface (addr, data, direction_rw, fb_start/fb_done) between two requesters.
- Typical requesters: score-store logic (A) and display/readback logic (B).
- Serialises their requests with round-robin priority, sequences the fb_start pulse and waits for completion, then returns read data and an acknowledge to the winning requester.
- Enforces a post-operation gap and a completion timeout.

Parameters:
- GAP_CYCLES, 2, idle clocks after fb_done falls before the next command may issue (range 1..255).
- TIMEOUT_CYCLES, 4096, max clocks from fb_start to fb_done rising before the operation is abandoned (range 2..65535).

Ports:
- CLK_50MHZ  input  1  system clock, all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- a_req  input  1  requester A command request (level); held with a_rw/a_addr/a_wdata stable until a_ack.
- a_rw  input  1  0 = write, 1 = read (same encoding as direction_rw).
- a_addr  input  8  Flash byte address.
- a_wdata  input  8  write data (ignored for reads).
- a_ack  output  1  one-cycle completion pulse to A.
- a_rdata  output  8  last read byte for A; valid from the a_ack cycle.
- b_req, b_rw, b_addr, b_wdata, b_ack, b_rdata: identical to the A set, for requester B.
- fb_addr  output  8  address to Flash controller.
- fb_data  output  8  write data to Flash controller.
- fb_direction_rw  output  1  direction to Flash controller.
- fb_start  output  1  one-cycle start pulse to Flash controller.
- fb_done  input  1  Flash controller completion level, synchronous to CLK_50MHZ.
- fb_rdata  input  8  read byte from Flash controller, valid while fb_done is high.
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  one-cycle pulse when an operation times out.

Behaviour:
- All outputs are registered.
- Reset values:
  - All outputs 0.
  - last_grant = B, so A wins the first contention.
  - fb_done_q = 0, counters 0, state IDLE.
- Reset asserted mid-operation:
  - Immediately forces all outputs to 0 and state to IDLE.
  - The in-flight request is neither acked nor errored.
- fb_done edge detection: registered copy fb_done_q; done_rise = fb_done & ~fb_done_q.
- IDLE:
  - Arbitration when a_req or b_req is high:
    - Only one requester high: it is granted.
    - Both high: grant the one not equal to last_grant.
  - On grant:
    - Latch the granted addr/wdata/rw into fb_addr/fb_data/fb_direction_rw.
    - Record grant, update last_grant, go to ISSUE.
- ISSUE (1 cycle):
  - fb_start = 1; load timeout counter with 0.
  - Next state WAIT.
  - Request seen in IDLE at edge N gives fb_start high during cycle N+1.
- WAIT:
  - fb_start = 0; counter increments each cycle.
  - fb_addr/fb_data/fb_direction_rw held stable.
  - On done_rise:
    - If read, capture fb_rdata into the granted requester's rdata register.
    - Pulse the granted ack for exactly 1 cycle (same edge as the rdata update).
    - Go to GAP.
  - If the counter reaches TIMEOUT_CYCLES-1 without done_rise:
    - Pulse timeout_err and the granted ack.
    - rdata unchanged.
    - Go to GAP.
  - done_rise on the timeout cycle: done wins, no timeout_err.
- GAP:
  - Wait until fb_done == 0.
  - Then count GAP_CYCLES clocks; return to IDLE.
  - Requests are not sampled in GAP. The requester must drop req within GAP_CYCLES of its ack, else the still-high req is taken as a new request.
- The non-granted requester's req may rise or fall at any time; it is only sampled in IDLE. Its rdata and ack are untouched.
- Write operation: rdata of both requesters unchanged.
- The fb_* outputs keep their last value in IDLE/GAP; they are not cleared.
- Counter widths:
  - Timeout counter 16 bit, saturating (never wraps).
  - Gap counter 8 bit.

Test Plan:
1. Single write: after reset, A requests write addr 0x35 data 0xC9.
   - fb_start is one pulse exactly 1 cycle after IDLE sampling, with fb_addr=0x35, fb_data=0xC9, fb_direction_rw=0.
   - Model raises fb_done after 10 cycles → a_ack pulses 1 cycle; a_rdata stays 0x00.
2. Read return: A writes 0xF5←0x0D, then B reads 0xF5 with model returning 0x0D.
   - b_rdata=0x0D in the b_ack cycle; a_rdata unchanged.
   - Second fb_start occurs no earlier than GAP_CYCLES (2) cycles after fb_done falls.
3. Contention: a_req and b_req rise in the same cycle and both stay high for 4 operations.
   - Grant order A, B, A, B.
   - Never two fb_start pulses without an intervening done/timeout.
4. Timeout: TIMEOUT_CYCLES=16, model never asserts fb_done.
   - timeout_err and a_ack pulse together 15 cycles after the fb_start cycle; busy then falls after the gap.
   - The next request proceeds normally.
5. Reset mid-operation: assert RST during WAIT.
   - All outputs 0 asynchronously (before the next clock edge); no ack is generated.
   - After release, a pending b_req is served first over a simultaneous a_req? No: A wins (last_grant=B).
6. Held request: A keeps a_req high after ack.
   - A second identical operation issues after the gap, confirming the GAP sampling rule.
